// File: rtl/bmp_uart_streamer.sv
// Captures one frame of two-pixel beats into BMP file order, then streams the
// (optional) 54-byte BMP header and padded pixel rows to a byte-wide UART.
module bmp_uart_streamer #(
   parameter int unsigned WIDTH       = 10,
   parameter int unsigned HEIGHT      = 5,
   parameter int unsigned SEND_HEADER = 1
) (
   input  logic       HCLK,
   input  logic       HRESET,
   input  logic       HSYNC,
   input  logic [7:0] DATA_WRITE_R0,
   input  logic [7:0] DATA_WRITE_G0,
   input  logic [7:0] DATA_WRITE_B0,
   input  logic [7:0] DATA_WRITE_R1,
   input  logic [7:0] DATA_WRITE_G1,
   input  logic [7:0] DATA_WRITE_B1,
   input  logic       frame_restart,
   input  logic       TxD_done,
   output logic       TxD_start,
   output logic [7:0] transmitData,
   output logic       write_done,
   output logic       isTransmitted
);

   localparam int unsigned NBEATS    = WIDTH * HEIGHT / 2;
   localparam int unsigned HALF_W    = WIDTH / 2;
   localparam int unsigned ROW_PIX   = 3 * WIDTH;
   localparam int unsigned PAD       = (4 - (ROW_PIX % 4)) % 4;
   localparam int unsigned ROW_BYTES = ROW_PIX + PAD;
   localparam int unsigned IMG_SIZE  = HEIGHT * ROW_BYTES;
   localparam int unsigned HDR_BYTES = 54;
   localparam int unsigned HDR_SENT  = (SEND_HEADER != 0) ? HDR_BYTES : 0;
   localparam int unsigned TOTAL     = IMG_SIZE + HDR_SENT;
   localparam int unsigned MEM_BYTES = HEIGHT * ROW_PIX;
   localparam int unsigned BEAT_W    = $clog2(NBEATS) + 1;
   localparam int unsigned COL_W     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
   localparam int unsigned ROW_W     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int unsigned IDX_W     = $clog2(TOTAL + 1);
   localparam int unsigned TXC_W     = $clog2(ROW_BYTES);
   localparam int unsigned ADDR_W    = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

   typedef enum logic [1:0] {CAPTURE, SEND_START, SEND_WAIT, DONE} state_t;

   state_t              state, state_d;
   logic                start_d, wd_d, itx_d, wr_en, in_hdr;
   logic [7:0]          data_d, cur_byte;
   logic [BEAT_W-1:0]   beat_cnt, beat_d;
   logic [COL_W-1:0]    col_cnt, col_d;
   logic [ROW_W-1:0]    row_cnt, row_d, tx_row, trow_d;
   logic [IDX_W-1:0]    byte_idx, idx_d;
   logic [TXC_W-1:0]    tx_col, tcol_d;
   logic [ADDR_W-1:0]   wr_base, rd_addr;
   logic [7:0]          mem [MEM_BYTES];

   // Little-endian BMP/DIB header byte; the size field always counts the header.
   function automatic logic [7:0] hdr_byte(input int unsigned i);
      logic [31:0] v;
      int unsigned k;
      v = 32'd0;
      k = 0;
      if (i == 0) v = 32'h42;
      else if (i == 1) v = 32'h4D;
      else if (i >= 2 && i <= 5) begin v = IMG_SIZE + HDR_BYTES; k = i - 2; end
      else if (i >= 10 && i <= 13) begin v = HDR_BYTES; k = i - 10; end
      else if (i >= 14 && i <= 17) begin v = 32'd40; k = i - 14; end
      else if (i >= 18 && i <= 21) begin v = WIDTH; k = i - 18; end
      else if (i >= 22 && i <= 25) begin v = HEIGHT; k = i - 22; end
      else if (i >= 26 && i <= 27) begin v = 32'd1; k = i - 26; end
      else if (i >= 28 && i <= 29) begin v = 32'd24; k = i - 28; end
      else if (i >= 34 && i <= 37) begin v = IMG_SIZE; k = i - 34; end
      return 8'(v >> (8 * k));
   endfunction

   // Image row r lands in file row HEIGHT-1-r (BMP is stored bottom-up).
   assign wr_base = ADDR_W'((HEIGHT - 1 - 32'(row_cnt)) * ROW_PIX + 32'(col_cnt) * 6);
   assign rd_addr = ADDR_W'(32'(tx_row) * ROW_PIX + 32'(tx_col));
   assign in_hdr  = (SEND_HEADER != 0) && (32'(byte_idx) < HDR_BYTES);

   always_comb begin
      cur_byte = 8'h00;
      if (in_hdr)
         cur_byte = hdr_byte(32'(byte_idx));
      else if (32'(tx_col) < ROW_PIX)
         cur_byte = mem[rd_addr];
   end

   always_ff @(posedge HCLK) begin
      if (wr_en) begin
         mem[wr_base]              <= DATA_WRITE_B0;
         mem[wr_base + ADDR_W'(1)] <= DATA_WRITE_G0;
         mem[wr_base + ADDR_W'(2)] <= DATA_WRITE_R0;
         mem[wr_base + ADDR_W'(3)] <= DATA_WRITE_B1;
         mem[wr_base + ADDR_W'(4)] <= DATA_WRITE_G1;
         mem[wr_base + ADDR_W'(5)] <= DATA_WRITE_R1;
      end
   end

   always_comb begin
      state_d = state;
      start_d = 1'b0;
      data_d  = transmitData;
      wd_d    = write_done;
      itx_d   = isTransmitted;
      beat_d  = beat_cnt;
      col_d   = col_cnt;
      row_d   = row_cnt;
      idx_d   = byte_idx;
      tcol_d  = tx_col;
      trow_d  = tx_row;
      wr_en   = 1'b0;
      case (state)
         CAPTURE: begin
            if (HSYNC) begin
               wr_en  = !HRESET;
               beat_d = beat_cnt + BEAT_W'(1);
               if (col_cnt == COL_W'(HALF_W - 1)) begin
                  col_d = '0;
                  row_d = row_cnt + ROW_W'(1);
               end else begin
                  col_d = col_cnt + COL_W'(1);
               end
               if (beat_cnt == BEAT_W'(NBEATS - 1)) begin
                  state_d = SEND_START;
                  wd_d    = 1'b1;
               end
            end
         end
         SEND_START: begin
            start_d = 1'b1;
            data_d  = cur_byte;
            state_d = SEND_WAIT;
         end
         SEND_WAIT: begin
            // A done pulse that lines up with our own start belongs to the previous byte.
            if (TxD_done && !TxD_start) begin
               idx_d = byte_idx + IDX_W'(1);
               if (!in_hdr) begin
                  if (tx_col == TXC_W'(ROW_BYTES - 1)) begin
                     tcol_d = '0;
                     trow_d = tx_row + ROW_W'(1);
                  end else begin
                     tcol_d = tx_col + TXC_W'(1);
                  end
               end
               if (32'(byte_idx) == TOTAL - 1) begin
                  state_d = DONE;
                  itx_d   = 1'b1;
               end else begin
                  state_d = SEND_START;
               end
            end
         end
         DONE: begin
            if (frame_restart) begin
               state_d = CAPTURE;
               wd_d    = 1'b0;
               itx_d   = 1'b0;
               beat_d  = '0;
               col_d   = '0;
               row_d   = '0;
               idx_d   = '0;
               tcol_d  = '0;
               trow_d  = '0;
            end
         end
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state         <= CAPTURE;
         TxD_start     <= 1'b0;
         transmitData  <= 8'h00;
         write_done    <= 1'b0;
         isTransmitted <= 1'b0;
         beat_cnt      <= '0;
         col_cnt       <= '0;
         row_cnt       <= '0;
         byte_idx      <= '0;
         tx_col        <= '0;
         tx_row        <= '0;
      end else begin
         state         <= state_d;
         TxD_start     <= start_d;
         transmitData  <= data_d;
         write_done    <= wd_d;
         isTransmitted <= itx_d;
         beat_cnt      <= beat_d;
         col_cnt       <= col_d;
         row_cnt       <= row_d;
         byte_idx      <= idx_d;
         tx_col        <= tcol_d;
         tx_row        <= trow_d;
      end
   end

endmodule

// File: tb/tb_bmp_uart_streamer.sv
// Directed bench: a 10x5 instance with header and a 4x2 instance without header.
module tb_bmp_uart_streamer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       restart = 1'b0;
   logic       a_hsync = 1'b0, a_done = 1'b0, b_hsync = 1'b0, b_done = 1'b0;
   logic [7:0] a_px [6];
   logic [7:0] b_px [6];
   logic       a_start, a_wd, a_tx, b_start, b_wd, b_tx;
   logic [7:0] a_data, b_data;
   int         total = 0;
   int         bad = 0;

   logic [7:0] exp_a [214];
   logic [7:0] hdr [54] = '{8'h42, 8'h4D, 8'hD6, 8'h00, 8'h00, 8'h00,
                            8'h00, 8'h00, 8'h00, 8'h00,
                            8'h36, 8'h00, 8'h00, 8'h00,
                            8'h28, 8'h00, 8'h00, 8'h00,
                            8'h0A, 8'h00, 8'h00, 8'h00,
                            8'h05, 8'h00, 8'h00, 8'h00,
                            8'h01, 8'h00, 8'h18, 8'h00,
                            8'h00, 8'h00, 8'h00, 8'h00,
                            8'hA0, 8'h00, 8'h00, 8'h00,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
   // 4x2 frame beats in R0 G0 B0 R1 G1 B1 order, and the resulting file bytes.
   logic [7:0] b_in [24] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                             8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC,
                             8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                             8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
   logic [7:0] exp_b [24] = '{8'h03, 8'h02, 8'h01, 8'h06, 8'h05, 8'h04,
                              8'h09, 8'h08, 8'h07, 8'h0C, 8'h0B, 8'h0A,
                              8'h33, 8'h22, 8'h11, 8'h66, 8'h55, 8'h44,
                              8'h99, 8'h88, 8'h77, 8'hCC, 8'hBB, 8'hAA};

   always #5 clk = ~clk;

   bmp_uart_streamer u_a (
      .HCLK(clk), .HRESET(rst), .HSYNC(a_hsync),
      .DATA_WRITE_R0(a_px[0]), .DATA_WRITE_G0(a_px[1]), .DATA_WRITE_B0(a_px[2]),
      .DATA_WRITE_R1(a_px[3]), .DATA_WRITE_G1(a_px[4]), .DATA_WRITE_B1(a_px[5]),
      .frame_restart(restart), .TxD_done(a_done),
      .TxD_start(a_start), .transmitData(a_data), .write_done(a_wd), .isTransmitted(a_tx));

   bmp_uart_streamer #(.WIDTH(4), .HEIGHT(2), .SEND_HEADER(0)) u_b (
      .HCLK(clk), .HRESET(rst), .HSYNC(b_hsync),
      .DATA_WRITE_R0(b_px[0]), .DATA_WRITE_G0(b_px[1]), .DATA_WRITE_B0(b_px[2]),
      .DATA_WRITE_R1(b_px[3]), .DATA_WRITE_G1(b_px[4]), .DATA_WRITE_B1(b_px[5]),
      .frame_restart(restart), .TxD_done(b_done),
      .TxD_start(b_start), .transmitData(b_data), .write_done(b_wd), .isTransmitted(b_tx));

   function automatic logic [7:0] pix(input int seed, input int b, input int k);
      return 8'(seed + 6 * b + k);
   endfunction

   task automatic build_exp_a(input int seed);
      int p;
      for (int i = 0; i < 54; i++) exp_a[i] = hdr[i];
      p = 54;
      for (int f = 0; f < 5; f++) begin
         for (int c = 0; c < 5; c++) begin
            int b;
            b = (4 - f) * 5 + c;
            exp_a[p]   = pix(seed, b, 2);
            exp_a[p+1] = pix(seed, b, 1);
            exp_a[p+2] = pix(seed, b, 0);
            exp_a[p+3] = pix(seed, b, 5);
            exp_a[p+4] = pix(seed, b, 4);
            exp_a[p+5] = pix(seed, b, 3);
            p += 6;
         end
         exp_a[p]   = 8'h00;
         exp_a[p+1] = 8'h00;
         p += 2;
      end
   endtask

   task automatic drive_frame_a(input int seed, input bit stray);
      for (int b = 0; b < 25; b++) begin
         @(negedge clk);
         if (b == 24) begin
            total++;
            if (a_wd !== 1'b0) begin bad++; $display("FAIL wd_before_last got %b want 0", a_wd); end
         end
         a_hsync = 1'b1;
         a_done  = stray && (b < 3);
         for (int k = 0; k < 6; k++) a_px[k] = pix(seed, b, k);
      end
      @(negedge clk);
      a_hsync = 1'b0;
      a_done  = 1'b0;
      total++;
      if (a_wd !== 1'b1) begin bad++; $display("FAIL wd_after_last got %b want 1", a_wd); end
   endtask

   // Acts as the UART: answers each start with a done pulse and checks every byte.
   task automatic rx(input bit sel, input int len, input int stop_at, input int slow_idx,
                     input bit poke, output int n);
      int cyc;
      int wait_n;
      logic st, tx;
      logic [7:0] d, held, want;
      n = 0;
      cyc = 0;
      while (cyc < 10000) begin
         @(negedge clk); cyc++;
         st = sel ? b_start : a_start;
         tx = sel ? b_tx : a_tx;
         d  = sel ? b_data : a_data;
         if (tx) break;
         if (st) begin
            total++;
            if (n >= len) begin
               bad++; $display("FAIL extra_start n=%0d got %02h want none", n, d);
            end else begin
               want = sel ? exp_b[n] : exp_a[n];
               if (d !== want) begin bad++; $display("FAIL byte[%0d] got %02h want %02h", n, d, want); end
            end
            n++;
            held = d;
            if (n == stop_at) break;
            wait_n = (n - 1 == slow_idx) ? 50 : 10;
            for (int w = 1; w < wait_n; w++) begin
               @(negedge clk); cyc++;
               restart = poke && (n == 3) && (w == 4);
               st = sel ? b_start : a_start;
               d  = sel ? b_data : a_data;
               total++;
               if (st !== 1'b0 || d !== held) begin
                  bad++; $display("FAIL wait_hold n=%0d got start=%b data=%02h want start=0 data=%02h", n, st, d, held);
               end
            end
            restart = 1'b0;
            if (sel) b_done = 1'b1; else a_done = 1'b1;
            @(negedge clk); cyc++;
            b_done = 1'b0;
            a_done = 1'b0;
         end
      end
      if (cyc >= 10000) begin
         total++; bad++; $display("FAIL rx_timeout got n=%0d want %0d", n, len);
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < 6; k++) begin a_px[k] = 8'h00; b_px[k] = 8'h00; end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({a_start, a_data, a_wd, a_tx} !== 11'h0) begin
         bad++; $display("FAIL reset_a got %b_%02h_%b_%b want all 0", a_start, a_data, a_wd, a_tx);
      end
      total++;
      if ({b_start, b_data, b_wd, b_tx} !== 11'h0) begin
         bad++; $display("FAIL reset_b got %b_%02h_%b_%b want all 0", b_start, b_data, b_wd, b_tx);
      end
      rst = 1'b0;
   endtask

   task automatic test_small_no_header();
      int n;
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         b_hsync = 1'b1;
         for (int k = 0; k < 6; k++) b_px[k] = b_in[b * 6 + k];
      end
      @(negedge clk);
      b_hsync = 1'b0;
      rx(1'b1, 24, -1, -1, 1'b0, n);
      total++;
      if (n !== 24) begin bad++; $display("FAIL small_count got %0d want 24", n); end
      total++;
      if (b_tx !== 1'b1) begin bad++; $display("FAIL small_tx got %b want 1", b_tx); end
   endtask

   task automatic test_full_frame();
      int n;
      build_exp_a(1);
      drive_frame_a(1, 1'b1);
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               a_hsync = 1'b1;
               for (int k = 0; k < 6; k++) a_px[k] = 8'(8'hE0 + k);
               @(negedge clk);
            end
            a_hsync = 1'b0;
         end
         rx(1'b0, 214, -1, 5, 1'b0, n);
      join
      total++;
      if (n !== 214) begin bad++; $display("FAIL full_count got %0d want 214", n); end
      total++;
      if (a_tx !== 1'b1 || a_wd !== 1'b1) begin
         bad++; $display("FAIL full_flags got tx=%b wd=%b want 1 1", a_tx, a_wd);
      end
   endtask

   task automatic test_done_restart();
      int n;
      repeat (5) begin
         @(negedge clk);
         total++;
         if (a_start !== 1'b0 || a_tx !== 1'b1 || a_data !== 8'h00) begin
            bad++; $display("FAIL done_hold got start=%b tx=%b data=%02h want 0 1 00", a_start, a_tx, a_data);
         end
      end
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      total++;
      if (a_wd !== 1'b0 || a_tx !== 1'b0) begin
         bad++; $display("FAIL restart_flags got wd=%b tx=%b want 0 0", a_wd, a_tx);
      end
      build_exp_a(8'h20);
      drive_frame_a(8'h20, 1'b0);
      rx(1'b0, 214, -1, -1, 1'b1, n);
      total++;
      if (n !== 214 || a_tx !== 1'b1) begin
         bad++; $display("FAIL second_frame got n=%0d tx=%b want 214 1", n, a_tx);
      end
   endtask

   task automatic test_reset_mid_tx();
      int n;
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      build_exp_a(8'h40);
      drive_frame_a(8'h40, 1'b0);
      rx(1'b0, 214, 7, -1, 1'b0, n);
      total++;
      if (n !== 7) begin bad++; $display("FAIL partial_count got %0d want 7", n); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if ({a_start, a_data, a_wd, a_tx} !== 11'h0) begin
         bad++; $display("FAIL mid_reset got %b_%02h_%b_%b want all 0", a_start, a_data, a_wd, a_tx);
      end
      build_exp_a(8'h80);
      drive_frame_a(8'h80, 1'b0);
      rx(1'b0, 214, -1, -1, 1'b0, n);
      total++;
      if (n !== 214 || a_tx !== 1'b1) begin
         bad++; $display("FAIL after_reset got n=%0d tx=%b want 214 1", n, a_tx);
      end
   endtask

   initial begin
      test_reset();
      test_small_no_header();
      test_full_frame();
      test_done_restart();
      test_reset_mid_tx();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
